// File: rtl/deck_shuffler.sv
// Builds a deck of 2*PAIRS colour cards, optionally shuffles it with an
// LFSR-driven Fisher-Yates pass, and streams it to card memory.
module deck_shuffler #(
  parameter int          PAIRS  = 8,
  parameter int          ADDR_W = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shuffle_en,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              finished
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // INIT    | filling deck[k] with pair index k>>1
  // SHUFFLE | rejection-sampled Fisher-Yates, i counts down to 0
  // WRITE   | streaming deck to card memory, k counts up
  // DONE    | deck delivered, waiting for a new start
  typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, WRITE, DONE} state_t;

  localparam int                N    = 2 * PAIRS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [2:0]        deck [N];
  logic [ADDR_W-1:0] k, i, j, k_inc;
  logic              shuf_q;
  logic              swap, accept;

  function automatic logic [11:0] palette(input logic [2:0] p);
    case (p)
      3'd0:    palette = 12'hF00;
      3'd1:    palette = 12'hFF0;
      3'd2:    palette = 12'hFFF;
      3'd3:    palette = 12'h00F;
      3'd4:    palette = 12'h0FF;
      3'd5:    palette = 12'hF0F;
      3'd6:    palette = 12'h0F0;
      default: palette = 12'hF80;
    endcase
  endfunction

  assign j      = lfsr[ADDR_W-1:0];
  assign k_inc  = k + ONE;
  assign swap   = (state == SHUFFLE) && (j <= i);
  assign accept = (state == WRITE) && wr_en && wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = INIT;
      INIT:       if (k == LAST) state_nxt = shuf_q ? SHUFFLE : WRITE;
      SHUFFLE:    if (swap && i == ONE) state_nxt = WRITE;
      WRITE:      if (accept && k == LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Galois form of x^16+x^14+x^13+x^11+1; free-running so each deal sees a new stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      deck[k] <= 3'(k >> 1);
    end else if (swap) begin
      deck[i] <= deck[j];
      deck[j] <= deck[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= '0;
      i        <= '0;
      shuf_q   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 12'h000;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shuf_q   <= shuffle_en;
            busy     <= 1'b1;
            finished <= 1'b0;
            k        <= '0;
          end
        end
        INIT: begin
          if (k == LAST) begin
            k <= '0;
            i <= LAST;
          end else begin
            k <= k_inc;
          end
        end
        SHUFFLE: begin
          if (swap) i <= i - ONE;
        end
        WRITE: begin
          // first WRITE cycle only loads the output registers for slot 0
          if (!wr_en) begin
            wr_en   <= 1'b1;
            wr_addr <= k;
            wr_data <= palette(deck[k]);
          end else if (wr_ready) begin
            if (k == LAST) begin
              wr_en    <= 1'b0;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              k       <= k_inc;
              wr_addr <= k_inc;
              wr_data <= palette(deck[k_inc]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: ordered, backpressured, shuffled and
// interrupted deals on a 16-card deck, plus a 6-card instance.
module tb_deck_shuffler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start = 1'b0, shuffle_en = 1'b0, wr_ready = 1'b0;
  logic        wr_en, busy, finished;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;

  logic        start_s = 1'b0, wr_ready_s = 1'b0;
  logic        wr_en_s, busy_s, finished_s;
  logic [2:0]  wr_addr_s;
  logic [11:0] wr_data_s;

  deck_shuffler #(.PAIRS(8), .ADDR_W(4), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .shuffle_en(shuffle_en), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .finished(finished)
  );

  deck_shuffler #(.PAIRS(3), .ADDR_W(3), .SEED(16'h1D2B)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .shuffle_en(1'b0), .wr_ready(wr_ready_s),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .busy(busy_s), .finished(finished_s)
  );

  int          n_cmp = 0, n_err = 0;
  logic [15:0] exp_q [$];
  logic [11:0] pal [8] = '{12'hF00, 12'hFF0, 12'hFFF, 12'h00F, 12'h0FF, 12'hF0F, 12'h0F0, 12'hF80};
  bit          held_v = 0, shuf_mode = 0;
  logic [3:0]  held_a;
  logic [11:0] held_d;
  int          seen [16];
  logic [11:0] lay [16], lay1 [16];
  int          n_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at the falling edge once wr_ready for the coming rising edge is driven.
  task automatic sample(input bit r);
    logic [15:0] e;
    if (held_v) begin
      check("hold_en", 32'(wr_en), 32'd1);
      check("hold_word", 32'({wr_addr, wr_data}), 32'({held_a, held_d}));
    end
    held_v = 0;
    if (wr_en) begin
      if (r) begin
        n_acc++;
        if (shuf_mode) begin
          seen[wr_addr]++;
          lay[wr_addr] = wr_data;
        end else begin
          check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write", 32'({wr_addr, wr_data}), 32'(e));
          end
        end
      end else begin
        held_v = 1;
        held_a = wr_addr;
        held_d = wr_data;
      end
    end
  endtask

  task automatic push_ordered(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({4'(k), pal[k >> 1]});
  endtask

  // lat counts rising edges from the one that samples start up to the one that sets finished.
  task automatic deal(input bit shuf, input bit bp, input int poke, input int budget,
                      output int lat, output int busy_cnt);
    int stall;
    bit r;
    stall    = bp ? 3 : 0;
    held_v   = 0;
    n_acc    = 0;
    busy_cnt = 0;
    @(negedge clk);
    start      = 1'b1;
    shuffle_en = shuf;
    wr_ready   = 1'b1;
    lat        = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      start      = (lat == poke);
      shuffle_en = ~shuffle_en;
      if (busy) busy_cnt++;
      if (finished) break;
      if (!bp) r = 1'b1;
      else if (wr_en && stall > 0) begin
        r = 1'b0;
        stall--;
      end else r = 1'($urandom_range(0, 1));
      wr_ready = r;
      sample(r);
    end
    check("deal_finished", 32'(finished), 32'd1);
    check("deal_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, bc, cnt, diff;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({wr_en, wr_addr, wr_data, busy, finished}), 32'd0);
    check("rst_outs_s", 32'({wr_en_s, wr_addr_s, wr_data_s, busy_s, finished_s}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_outs", 32'({wr_en, wr_addr, wr_data, busy, finished}), 32'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en || busy || finished) cnt++;
    end
    check("idle_quiet", 32'(cnt), 32'd0);

    // ordered layout, full-rate memory
    push_ordered(16);
    deal(1'b0, 1'b0, 0, 100, lat, bc);
    check("ord_latency", 32'(lat), 32'd34);
    check("ord_busy_cycles", 32'(bc), 32'd33);
    check("ord_writes", 32'(n_acc), 32'd16);
    check("ord_queue_empty", 32'(exp_q.size()), 32'd0);

    // backpressure, first write stalled
    push_ordered(16);
    deal(1'b0, 1'b1, 0, 400, lat, bc);
    check("bp_writes", 32'(n_acc), 32'd16);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("bp_latency_grew", 32'(lat > 34), 32'd1);

    // start during WRITE is ignored
    push_ordered(16);
    deal(1'b0, 1'b0, 20, 100, lat, bc);
    check("ign_latency", 32'(lat), 32'd34);
    check("ign_queue_empty", 32'(exp_q.size()), 32'd0);

    // two shuffled deals
    shuf_mode = 1;
    for (int run = 0; run < 2; run++) begin
      for (int a = 0; a < 16; a++) begin
        seen[a] = 0;
        lay[a]  = 12'h000;
      end
      deal(1'b1, 1'b0, 0, 2000, lat, bc);
      check("shuf_latency_min", 32'(lat >= 49), 32'd1);
      for (int a = 0; a < 16; a++) check("shuf_addr_once", 32'(seen[a]), 32'd1);
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int a = 0; a < 16; a++) if (lay[a] == pal[c]) cnt++;
        check("shuf_colour_twice", 32'(cnt), 32'd2);
      end
      diff = 0;
      if (run == 0) begin
        for (int a = 0; a < 16; a++) begin
          if (lay[a] != pal[a >> 1]) diff++;
          lay1[a] = lay[a];
        end
        check("shuf_not_ordered", 32'(diff != 0), 32'd1);
      end else begin
        for (int a = 0; a < 16; a++) if (lay[a] != lay1[a]) diff++;
        check("shuf_layouts_differ", 32'(diff != 0), 32'd1);
      end
    end
    shuf_mode = 0;

    // reset while presenting write 5
    push_ordered(16);
    held_v = 0;
    @(negedge clk);
    start      = 1'b1;
    shuffle_en = 1'b0;
    wr_ready   = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (wr_en && wr_addr == 4'd5) break;
      sample(1'b1);
    end
    check("mid_reached_k5", 32'(wr_en && wr_addr == 4'd5), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_outs", 32'({wr_en, wr_addr, wr_data, busy, finished}), 32'd0);
    exp_q.delete();
    held_v = 0;
    @(negedge clk);
    rst = 1'b1;
    push_ordered(16);
    deal(1'b0, 1'b0, 0, 100, lat, bc);
    check("redeal_latency", 32'(lat), 32'd34);
    check("redeal_writes", 32'(n_acc), 32'd16);
    check("redeal_queue_empty", 32'(exp_q.size()), 32'd0);

    // six-card instance
    for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, 3'(k), pal[k >> 1]});
    @(negedge clk);
    start_s    = 1'b1;
    wr_ready_s = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      start_s = 1'b0;
      if (finished_s) break;
      if (wr_en_s) begin
        check("small_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("small_write", 32'({1'b0, wr_addr_s, wr_data_s}), 32'(exp_q.pop_front()));
      end
    end
    check("small_finished", 32'(finished_s), 32'd1);
    check("small_latency", 32'(lat), 32'd14);
    check("small_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
Parametrised successor to the fixed-layout card colour generator. It builds a deck of 2*PAIRS cards, each colour appearing exactly twice. It can optionally randomise the layout with an LFSR-driven Fisher-Yates shuffle. It then streams the deck into the board card memory over a ready/valid write port and flags completion to the game FSM.

Parameters:
- PAIRS, 8: number of card pairs; legal range 2..8.
- ADDR_W, 4: card address width; must satisfy 2^ADDR_W >= 2*PAIRS.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  single-cycle request to deal a new deck; honoured only in IDLE or DONE.
- shuffle_en  input  1  sampled on accepted start; 1 = randomised layout, 0 = ordered layout.
- wr_ready  input  1  card memory can accept a write this cycle.
- wr_en  output  1  write valid.
- wr_addr  output  ADDR_W  card slot being written.
- wr_data  output  12  RGB444 colour for that slot.
- busy  output  1  high from accepted start until the last write is accepted.
- finished  output  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - wr_en=0, wr_addr=0, wr_data=12'h000, busy=0, finished=0.
  - LFSR=SEED; deck array contents don't-care.
- All outputs are registered.
- Palette, indexed by pair number p (0..7): F00, FF0, FFF, 00F, 0FF, F0F, 0F0, F80.
- N = 2*PAIRS.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle except during reset; never reaches zero.
- Internal deck: N entries of 3 bits, holding pair indices.
- States:
  - IDLE:
    - On start: latch shuffle_en, busy<=1, finished<=0, go to INIT with k=0.
  - INIT:
    - One entry per cycle: deck[k]=k>>1, for k=0..N-1 (N cycles).
    - Then go to SHUFFLE with i=N-1 if shuffle_en was latched high, otherwise to WRITE with k=0.
  - SHUFFLE (rejection-sampled Fisher-Yates):
    - Each cycle, j = LFSR[ADDR_W-1:0].
    - If j<=i: swap deck[i] and deck[j], then i<=i-1.
    - If j>i: no swap; retry next cycle with the new LFSR value.
    - When i reaches 0 after a swap, go to WRITE with k=0.
  - WRITE:
    - wr_en=1, wr_addr=k, wr_data=palette[deck[k]].
    - A write is accepted when wr_en and wr_ready are both high.
    - On acceptance: k<=k+1; the next write is presented the following cycle.
    - While wr_ready=0: wr_en, wr_addr and wr_data hold stable; no combinational path from wr_ready to outputs.
    - After the write of k=N-1 is accepted: wr_en<=0, busy<=0, finished<=1, go to DONE.
  - DONE:
    - finished stays 1. start re-enters INIT as from IDLE and clears finished the next cycle.
- Timing:
  - Ordered-layout latency, start to finished with wr_ready=1 throughout: 1 + N + N + 1 cycles (for N=16: 34).
  - With shuffle, latency grows by the variable SHUFFLE duration.
- Boundary conditions:
  - start while busy: ignored; shuffle_en not re-latched.
  - shuffle_en changing after start: no effect.
  - wr_ready low on the very first write: address 0 held, no skip.
  - Reset asserted mid-WRITE or mid-SHUFFLE: immediate return to reset values; the memory is left partially written and the next start fully rewrites it.
  - Unused addresses N..2^ADDR_W-1 are never written.
  - k and i are ADDR_W bits wide; no wrap beyond N-1.

Test Plan:
1. Reset values: hold rst=0 for 3 cycles, release -> all outputs 0. Then idle 10 cycles with no start -> wr_en stays 0.
2. Ordered layout: PAIRS=8, shuffle_en=0, start, wr_ready=1 ->
   - 16 writes, addr 0..15, data F00,F00,FF0,FF0,FFF,FFF,00F,00F,0FF,0FF,F0F,F0F,0F0,0F0,F80,F80.
   - finished rises exactly 34 cycles after start; busy falls in the same cycle.
3. Backpressure: ordered run with wr_ready toggled by a pseudo-random pattern -> identical address/data sequence. Each write is held unchanged while wr_ready=0; no duplicates or skips.
4. Shuffle: shuffle_en=1, PAIRS=8, two consecutive deals ->
   - each run writes every address 0..15 exactly once;
   - each of the 8 colours appears exactly twice;
   - the two layouts differ.
5. Ignored start and mid-run reset:
   - start pulsed during WRITE -> no restart; sequence completes.
   - rst=0 at write k=5 -> outputs zeroed immediately.
   - A new start after release -> full deal from address 0.
6. Small deck: PAIRS=3, ADDR_W=3, shuffle_en=0 -> 6 writes, addr 0..5, data F00,F00,FF0,FF0,FFF,FFF; finished after 14 cycles.
